mem_stage: RTL and testbench

MEM pipeline stage of the five-stage MIPS core. It sits between EX and WB. It registers the EX-to-MEM bus under stall control and extracts load data from the synchronous data SRAM read port. It also selects the register-file write value and forwards the MEM-stage result to ID. It holds load data captured during MEM stalls, so a stalled load never loses its SRAM read data.

---
 rtl/mem_stage_pkg.sv | 58 +++++
 rtl/mem_stage_load_align.sv | 48 ++++
 rtl/mem_stage.sv | 99 +++++++++
 tb/tb_mem_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// ============================================================================
// Module  : mem_stage_pkg
// Brief   : Shared constants, bus layout and load decode for the MEM stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_stage_pkg;

  // Stall vector layout; a set bit means that stage is stopped.
  localparam int   STALL_W   = 6;
  localparam int   STALL_EX  = 3;
  localparam int   STALL_MEM = 4;
  localparam logic STOP      = 1'b1;
  localparam logic NOSTOP    = 1'b0;

  localparam int EX_TO_MEM_WD = 76;
  localparam int MEM_TO_WB_WD = 70;
  localparam int EX_TO_MEM_BW = EX_TO_MEM_WD + 64 + 1 + 2 + 4;
  localparam int MEM_TO_WB_BW = MEM_TO_WB_WD + 64 + 3;
  localparam int FWD_BW       = 3 + 64 + 1 + 5 + 32;

  localparam logic [3:0] LOAD_LW  = 4'b0000;
  localparam logic [3:0] LOAD_LB  = 4'b1001;
  localparam logic [3:0] LOAD_LBU = 4'b0001;
  localparam logic [3:0] LOAD_LH  = 4'b1011;
  localparam logic [3:0] LOAD_LHU = 4'b0011;
  localparam int         LS_SIGN_BIT = 3;

  typedef enum logic [1:0] {
    LSZ_WORD = 2'b00,
    LSZ_BYTE = 2'b01,
    LSZ_HALF = 2'b11
  } load_size_e;

  // Field order is MSB to LSB of the EX-to-MEM bus.
  typedef struct packed {
    logic [3:0]  load_select;
    logic        lo_wen;
    logic        hi_wen;
    logic        muldiv;
    logic [63:0] hilo_data;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  function automatic logic is_load(input ex_mem_t b);
    return b.data_ram_en & (b.data_ram_wen == 4'b0000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_load_align.sv
// ============================================================================
// Module  : load_align
// Brief   : Byte/halfword lane selection and sign/zero extension of load data.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [3:0]  load_select_i,
  output logic [31:0] result_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;
  logic        unused_sel;

  assign unused_sel = load_select_i[2];
  assign w_sign     = load_select_i[LS_SIGN_BIT];

  always_comb begin
    case (addr_i)
      2'd0:    w_byte = rdata_i[7:0];
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      default: w_byte = rdata_i[31:24];
    endcase
  end

  // Misaligned halfword addresses simply ignore bit 0; no exception is raised here.
  assign w_half = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    result_o = rdata_i;
    case (load_size_e'(load_select_i[1:0]))
      LSZ_BYTE: result_o = {{24{w_sign & w_byte[7]}}, w_byte};
      LSZ_HALF: result_o = {{16{w_sign & w_half[15]}}, w_half};
      default:  result_o = rdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module  : mem_stage
// Brief   : MEM pipeline stage: EX/MEM register, load extraction, WB/ID buses.
//           Optional MEM_LOAD_HOLD_EN keeps a stalled load's SRAM read data.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int EX_TO_MEM_W = 147,
  parameter int MEM_TO_WB_W = 137
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic [EX_TO_MEM_W-1:0] ex_to_mem_bus,
  input  logic [31:0]            data_sram_rdata,
  output logic [MEM_TO_WB_W-1:0] mem_to_wb_bus,
  output logic [FWD_BW-1:0]      mem_to_id_forwarding,
  output logic                   mem_is_load
);

  ex_mem_t     w_ex;
  ex_mem_t     mem_q;
  ex_mem_t     mem_d;
  logic [31:0] w_load_raw;
  logic [31:0] w_load_aligned;
  logic [31:0] w_rf_wdata;
  logic        unused_stall;

  assign w_ex         = ex_to_mem_bus;
  assign unused_stall = ^{stall[STALL_W-1:STALL_MEM+1], stall[STALL_EX-1:0]};

  always_comb begin
    mem_d = mem_q;
    if (stall[STALL_EX] == STOP && stall[STALL_MEM] == NOSTOP) begin
      mem_d = '0;
    end else if (stall[STALL_EX] == NOSTOP) begin
      mem_d = w_ex;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

`ifdef MEM_LOAD_HOLD_EN
  logic        first_q;
  logic        first_d;
  logic [31:0] hold_q;
  logic [31:0] hold_d;

  // The SRAM only presents read data in the first MEM cycle of a load;
  // later stalled cycles replay the copy captured then.
  assign first_d = (stall[STALL_EX] == NOSTOP) && is_load(w_ex);
  assign hold_d  = first_q ? data_sram_rdata : hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      first_q <= first_d;
      hold_q  <= hold_d;
    end
  end

  assign w_load_raw = first_q ? data_sram_rdata : hold_q;
`else
  assign w_load_raw = data_sram_rdata;
`endif

  load_align u_load_align (
    .rdata_i       (w_load_raw),
    .addr_i        (mem_q.ex_result[1:0]),
    .load_select_i (mem_q.load_select),
    .result_o      (w_load_aligned)
  );

  assign w_rf_wdata  = mem_q.sel_rf_res ? w_load_aligned : mem_q.ex_result;
  assign mem_is_load = is_load(mem_q);

  assign mem_to_wb_bus = {mem_q.lo_wen, mem_q.hi_wen, mem_q.muldiv,
                          mem_q.hilo_data, mem_q.pc,
                          mem_q.rf_we, mem_q.rf_waddr, w_rf_wdata};

  assign mem_to_id_forwarding = {mem_q.lo_wen, mem_q.hi_wen, mem_q.muldiv,
                                 mem_q.hilo_data,
                                 mem_q.rf_we, mem_q.rf_waddr, w_rf_wdata};

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module  : tb_mem_stage
// Brief   : Self-checking bench for mem_stage: load vectors, stalls, reset.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_stage;

  localparam logic [5:0] ST_RUN    = 6'b000000;
  localparam logic [5:0] ST_HOLD   = 6'b011111;
  localparam logic [5:0] ST_BUBBLE = 6'b001111;
  localparam int         NV        = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [146:0] ex_to_mem_bus;
  logic [31:0]  data_sram_rdata;
  logic [136:0] mem_to_wb_bus;
  logic [104:0] mem_to_id_forwarding;
  logic         mem_is_load;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage #(.EX_TO_MEM_W(147), .MEM_TO_WB_W(137)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall                (stall),
    .ex_to_mem_bus        (ex_to_mem_bus),
    .data_sram_rdata      (data_sram_rdata),
    .mem_to_wb_bus        (mem_to_wb_bus),
    .mem_to_id_forwarding (mem_to_id_forwarding),
    .mem_is_load          (mem_is_load)
  );

  typedef struct {
    logic [3:0]  ls;
    logic        en;
    logic [3:0]  wen;
    logic        sel;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] res;
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
    logic        exp_load;
  } vec_t;

  typedef struct {
    logic [136:0] wb;
    logic [104:0] fwd;
    logic         ld;
  } exp_t;

  vec_t vec [NV];
  exp_t sb [$];

  function automatic logic [146:0] mk(input logic [3:0] ls, input logic [2:0] flags,
                                      input logic [63:0] hilo, input logic [31:0] pc,
                                      input logic en, input logic [3:0] wen,
                                      input logic sel, input logic we,
                                      input logic [4:0] wa, input logic [31:0] res);
    return {ls, flags, hilo, pc, en, wen, sel, we, wa, res};
  endfunction

  function automatic logic [136:0] exp_wb(input logic [146:0] b, input logic [31:0] wd);
    return {b[142:140], b[139:76], b[75:44], b[37], b[36:32], wd};
  endfunction

  function automatic logic [104:0] exp_fwd(input logic [146:0] b, input logic [31:0] wd);
    return {b[142:140], b[139:76], b[37], b[36:32], wd};
  endfunction

  task automatic check(input string name, input logic [136:0] act, input logic [136:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " wb"},  mem_to_wb_bus, 137'(0));
    check({tag, " fwd"}, 137'(mem_to_id_forwarding), 137'(0));
    check({tag, " ld"},  137'(mem_is_load), 137'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [146:0] bus;
    exp_t         e;
    logic [31:0]  hold_exp;

    vec[0]  = '{LS(4'b1001), 1'b1, 4'h0, 1'b1, 1'b1, 5'd3,  32'h1000_0003, 32'h80FF_1234, 32'hFFFF_FF80, 1'b1};
    vec[1]  = '{LS(4'b0001), 1'b1, 4'h0, 1'b1, 1'b1, 5'd4,  32'h1000_0003, 32'h80FF_1234, 32'h0000_0080, 1'b1};
    vec[2]  = '{LS(4'b1011), 1'b1, 4'h0, 1'b1, 1'b1, 5'd5,  32'h1000_0002, 32'h8001_7FFF, 32'hFFFF_8001, 1'b1};
    vec[3]  = '{LS(4'b0011), 1'b1, 4'h0, 1'b1, 1'b1, 5'd6,  32'h1000_0000, 32'h8001_7FFF, 32'h0000_7FFF, 1'b1};
    vec[4]  = '{LS(4'b0000), 1'b1, 4'h0, 1'b1, 1'b1, 5'd7,  32'h1000_0100, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1};
    vec[5]  = '{LS(4'b1001), 1'b1, 4'h0, 1'b1, 1'b1, 5'd8,  32'h1000_0001, 32'h1234_8756, 32'hFFFF_FF87, 1'b1};
    vec[6]  = '{LS(4'b0001), 1'b1, 4'h0, 1'b1, 1'b1, 5'd9,  32'h1000_0000, 32'h0000_00FF, 32'h0000_00FF, 1'b1};
    vec[7]  = '{LS(4'b1011), 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h1000_0003, 32'h7ABC_0000, 32'h0000_7ABC, 1'b1};
    vec[8]  = '{LS(4'b0011), 1'b1, 4'h0, 1'b1, 1'b1, 5'd12, 32'h1000_0002, 32'hFFFE_0001, 32'h0000_FFFE, 1'b1};
    vec[9]  = '{LS(4'b1011), 1'b1, 4'h0, 1'b1, 1'b1, 5'd13, 32'h1000_0000, 32'h0000_8000, 32'hFFFF_8000, 1'b1};
    vec[10] = '{LS(4'b0000), 1'b1, 4'hF, 1'b0, 1'b0, 5'd0,  32'h1000_0040, 32'hFFFF_FFFF, 32'h1000_0040, 1'b0};
    vec[11] = '{LS(4'b0000), 1'b0, 4'h0, 1'b0, 1'b1, 5'd11, 32'hCAFE_BABE, 32'h5555_5555, 32'hCAFE_BABE, 1'b0};

    rst             = 1'b0;
    stall           = ST_RUN;
    ex_to_mem_bus   = '0;
    data_sram_rdata = '0;

    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Table: every instruction registered one clock after EX drives it.
    for (int i = 0; i < NV; i++) begin
      bus = mk(vec[i].ls, 3'(i), {32'(i), 32'hA5A5_0000}, 32'h0040_0000 + 32'(i * 4),
               vec[i].en, vec[i].wen, vec[i].sel, vec[i].we, vec[i].wa, vec[i].res);
      ex_to_mem_bus = bus;
      sb.push_back('{exp_wb(bus, vec[i].exp_wdata), exp_fwd(bus, vec[i].exp_wdata), vec[i].exp_load});
      @(posedge clk);
      #1 data_sram_rdata = vec[i].rdata;
      @(negedge clk);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL vec%0d sb: actual empty required entry", i);
      end else begin
        e = sb.pop_front();
        check($sformatf("vec%0d wb", i),  mem_to_wb_bus, e.wb);
        check($sformatf("vec%0d fwd", i), 137'(mem_to_id_forwarding), 137'(e.fwd));
        check($sformatf("vec%0d ld", i),  137'(mem_is_load), 137'(e.ld));
      end
    end

    // Stalled LW: SRAM data changes while MEM is stopped.
    ex_to_mem_bus = mk(4'b0000, 3'b000, 64'h0, 32'h0040_0100, 1'b1, 4'h0, 1'b1, 1'b1, 5'd20, 32'h1000_0200);
    @(posedge clk);
    #1;
    data_sram_rdata = 32'h1111_1111;
    stall           = ST_HOLD;
    @(negedge clk);
    check("hold first", 137'(mem_to_wb_bus[31:0]), 137'(32'h1111_1111));
`ifdef MEM_LOAD_HOLD_EN
    hold_exp = 32'h1111_1111;
`else
    hold_exp = 32'h2222_2222;
`endif
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 data_sram_rdata = 32'h2222_2222;
      @(negedge clk);
      check($sformatf("hold cyc%0d", c), 137'(mem_to_wb_bus[31:0]), 137'(hold_exp));
      check($sformatf("hold ld%0d", c),  137'(mem_is_load), 137'(1));
    end

    // Bubble: EX stopped, MEM free.
    stall = ST_BUBBLE;
    @(posedge clk);
    @(negedge clk);
    check_zero("bubble");
    stall = ST_RUN;
    bus   = mk(4'b0000, 3'b000, 64'h0, 32'h0040_0200, 1'b0, 4'h0, 1'b0, 1'b1, 5'd21, 32'h1234_5678);
    ex_to_mem_bus = bus;
    @(posedge clk);
    @(negedge clk);
    check("after bubble", mem_to_wb_bus, exp_wb(bus, 32'h1234_5678));

    // MTHI: hi_wen and hilo_data reach WB and ID in the same cycle.
    bus = mk(4'b0000, 3'b010, 64'hDEAD_BEEF_0000_0000, 32'h0040_0204, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    ex_to_mem_bus = bus;
    @(posedge clk);
    @(negedge clk);
    check("mthi wb",   mem_to_wb_bus, exp_wb(bus, 32'h0));
    check("mthi fwd",  137'(mem_to_id_forwarding), 137'(exp_fwd(bus, 32'h0)));
    check("mthi hi",   137'(mem_to_id_forwarding[103]), 137'(1));
    check("mthi hilo", 137'(mem_to_id_forwarding[101:38]), 137'(64'hDEAD_BEEF_0000_0000));

    // Reset asserted between edges while a load is stalled in MEM.
    ex_to_mem_bus = mk(4'b0000, 3'b111, 64'h1, 32'h0040_0300, 1'b1, 4'h0, 1'b1, 1'b1, 5'd22, 32'h1000_0300);
    @(posedge clk);
    #1;
    stall           = ST_HOLD;
    data_sram_rdata = 32'h7777_7777;
    #2 rst = 1'b0;
    #1;
    check_zero("async rst");
    @(negedge clk);
    rst   = 1'b1;
    stall = ST_RUN;
    ex_to_mem_bus = mk(4'b0000, 3'b000, 64'h0, 32'h0040_0400, 1'b1, 4'h0, 1'b1, 1'b1, 5'd23, 32'h1000_0040);
    @(posedge clk);
    #1 data_sram_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    check("post rst lw",  137'(mem_to_wb_bus[31:0]), 137'(32'h0BAD_F00D));
    check("post rst ld",  137'(mem_is_load), 137'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic [3:0] LS(input logic [3:0] v);
    return v;
  endfunction

endmodule

`default_nettype wire
